// File: rtl/util_axis_tiny_fifo.sv
// Register-array AXI-Stream FIFO: 1-cycle write-to-valid latency, no full pass-through or empty bypass,
// registered ready/valid only. Optional occupancy port under UTIL_AXIS_TINY_FIFO_COUNT_EN.
module util_axis_tiny_fifo #(
  parameter int DEPTH     = 4,
  parameter int BUS_WIDTH = 1
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic [BUS_WIDTH*8-1:0]       s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [BUS_WIDTH*8-1:0]       m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  localparam int DW = BUS_WIDTH * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_s_rdy;
  logic          r_m_vld;

  logic          w_wr;
  logic          w_rd;
  logic [CW-1:0] w_count_next;

  // Handshakes are gated only by registered flags, so a read never frees a slot for a same-cycle write.
  assign w_wr         = s_axis_tvalid & r_s_rdy;
  assign w_rd         = m_axis_tready & r_m_vld;
  assign w_count_next = r_count + CW'(w_wr) - CW'(w_rd);

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_s_rdy <= 1'b0;
      r_m_vld <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= s_axis_tdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_next;
      r_s_rdy <= (w_count_next != CW'(DEPTH));
      r_m_vld <= (w_count_next != '0);
    end
  end

  assign s_axis_tready = r_s_rdy;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tdata  = r_mem[r_rptr];

`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
  assign occupancy = r_count;
`endif

endmodule

// File: tb/tb_util_axis_tiny_fifo.sv
// Directed bench for util_axis_tiny_fifo (DEPTH=4, BUS_WIDTH=1) with a queue reference for ordering and flags.
module tb_util_axis_tiny_fifo;

  logic       aclk = 1'b0;
  logic       arst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
  logic [2:0] occupancy;
`endif

  int tests  = 0;
  int failed = 0;
  logic [7:0] q [$];
  logic [7:0] exp_word;
  logic       acc;

  util_axis_tiny_fifo #(.DEPTH(4), .BUS_WIDTH(1)) dut (
    .aclk          (aclk),
    .arst          (arst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
    ,
    .occupancy     (occupancy)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One clock with reference tracking: flags checked against the queue depth, popped words against the queue head.
  task automatic cycle();
    check("flag_rdy", s_axis_tready, (q.size() != 4));
    check("flag_vld", m_axis_tvalid, (q.size() != 0));
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
    check("occupancy", occupancy, q.size());
`endif
    if (m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        check("underflow", 1, 0);
      end else begin
        exp_word = q.pop_front();
        check("data", m_axis_tdata, exp_word);
      end
    end
    if (s_axis_tvalid && s_axis_tready) q.push_back(s_axis_tdata);
    tick();
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 10 && (m_axis_tvalid || q.size() != 0); k++) cycle();
    check("drain_vld", m_axis_tvalid, 0);
    check("drain_lost", q.size(), 0);
  endtask

  initial begin
    // Reset with write attempted: nothing may be taken.
    arst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; m_axis_tready = 1'b0;
    tick(); tick();
    check("rst_rdy", s_axis_tready, 0);
    check("rst_vld", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 8'h00);
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
    check("rst_occ", occupancy, 0);
`endif
    arst = 1'b0;
    tick();
    check("rel_rdy", s_axis_tready, 1);
    check("rel_vld", m_axis_tvalid, 0);

    // Fill without reading: only the first four words are accepted.
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      s_axis_tdata = 8'(i);
      acc = s_axis_tready;
      check("fill_acc", acc, (i <= 4));
      cycle();
    end
    check("full_rdy", s_axis_tready, 0);
    check("full_vld", m_axis_tvalid, 1);
    check("full_head", m_axis_tdata, 8'h01);
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
    check("full_occ", occupancy, 4);
`endif

    // Drain from full: 01..04 in order, ready back after first read.
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_head", m_axis_tdata, 32'(k + 1));
      cycle();
      check("drain_rdy", s_axis_tready, 1);
    end
    check("drain_empty_vld", m_axis_tvalid, 0);

    // Streaming: both sides active, data wraps 0xFF -> 0x00, no gaps after first word.
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s_axis_tdata = 8'(i);
      cycle();
      check("stream_vld", m_axis_tvalid, 1);
      check("stream_lat", m_axis_tdata, 32'(i & 8'hFF));
    end
    drain();

    // Random backpressure with tvalid toggling every cycle.
    for (int i = 0; i < 300; i++) begin
      s_axis_tvalid = i[0];
      s_axis_tdata  = 8'($urandom_range(0, 255));
      m_axis_tready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    // Reset mid-operation with three words stored.
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = 8'h11 * 8'(i + 1);
      cycle();
    end
    check("pre_rst_vld", m_axis_tvalid, 1);
    s_axis_tvalid = 1'b0; arst = 1'b1;
    tick();
    q.delete();
    check("mid_rst_vld", m_axis_tvalid, 0);
    check("mid_rst_rdy", s_axis_tready, 0);
    check("mid_rst_tdata", m_axis_tdata, 8'h00);
`ifdef UTIL_AXIS_TINY_FIFO_COUNT_EN
    check("mid_rst_occ", occupancy, 0);
`endif
    arst = 1'b0;
    tick();
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5;
    cycle();
    s_axis_tvalid = 1'b0;
    check("post_rst_vld", m_axis_tvalid, 1);
    check("post_rst_head", m_axis_tdata, 8'hA5);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
